ram_write_arbiter: RTL
======================

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of each write word.
REQ-002 The block SHALL have parameter ADDR_BITS, default 4: RAM address width; each requester region holds 2^(ADDR_BITS-1) words.
REQ-003 The block SHALL have parameter BURST_MAX, default 4: maximum consecutive transfers per grant while the other requester waits.
REQ-004 The block SHALL have port clk_w, input, 1 bit: write clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous pointer and arbiter clear, active-high.
REQ-007 The block SHALL have ports req_a and req_b, input, 1 bit each: requester A/B holds a valid word.
REQ-008 The block SHALL have ports data_a and data_b, input, DATA_WIDTH each: requester A/B write word.
REQ-009 The block SHALL have ports gnt_a and gnt_b, output, 1 bit each, registered: requester A/B is granted.
REQ-010 The block SHALL have port en_w, output, 1 bit, registered: RAM write enable.
REQ-011 The block SHALL have port write_addr, output, ADDR_BITS, registered: RAM write address.
REQ-012 The block SHALL have port data, output, DATA_WIDTH, registered: RAM write data.
REQ-013 The block SHALL have ports wrap_a and wrap_b, output, 1 bit each, registered: one-cycle pulse on the last address of region A/B.

Function
REQ-014 The block SHALL count a transfer for X in any cycle where req_X=1 and gnt_X=1; only one of gnt_a and gnt_b SHALL be high at a time.
REQ-015 The block SHALL implement FSM states IDLE, GRANT_A and GRANT_B; gnt_a=1 only in GRANT_A and gnt_b=1 only in GRANT_B.
REQ-016 From IDLE, the FSM SHALL go to GRANT_A if req_a and (not req_b or last_granted=B), else to GRANT_B if req_b, else stay in IDLE.
REQ-017 last_granted SHALL update on every entry to GRANT_A or GRANT_B; it SHALL reset to B, so A wins the first tie.
REQ-018 In GRANT_X with req_X=0, the FSM SHALL go to GRANT_other if the other requester's req=1, else to IDLE.
REQ-019 In GRANT_X, a burst counter SHALL count transfers; the counter reaching BURST_MAX with the other req=1 SHALL move the FSM to GRANT_other.
REQ-020 If the counter reaches BURST_MAX with the other req=0, the FSM SHALL stay in GRANT_X and the counter SHALL restart at 0.
REQ-021 The burst counter SHALL clear on every state change.
REQ-022 Requester A SHALL write only addresses 0 .. 2^(ADDR_BITS-1)-1 and requester B only addresses with MSB=1, each via its own pointer.
REQ-023 Each pointer SHALL increment by 1 per transfer and wrap from the region top to the region base.
REQ-024 Write latency SHALL be 1 cycle: a transfer in cycle n gives en_w=1, write_addr=pointer, data=data_X in cycle n+1.
REQ-025 en_w SHALL be 0 in any cycle following a cycle with no transfer; write_addr and data SHALL hold their last values.
REQ-026 wrap_X SHALL be 1 in the same cycle as en_w for the top address of region X, and 0 otherwise.
REQ-027 clear=1 SHALL discard any same-cycle transfer (no en_w next cycle), set both pointers to their region base, set the FSM to IDLE, clear the burst counter and set last_granted to B.
REQ-028 reset SHALL take precedence over clear; clear SHALL take precedence over all other events.

Reset
REQ-029 While reset=0 at a clk_w edge, the block SHALL set gnt_a, gnt_b, en_w, wrap_a, wrap_b, write_addr and data to 0.
REQ-030 While reset=0 at a clk_w edge, the block SHALL set the FSM to IDLE, pointer A to 0, pointer B to 2^(ADDR_BITS-1), the burst counter to 0 and last_granted to B.
REQ-031 A transfer in progress when reset is asserted SHALL be discarded with no en_w afterwards.

Verification (DATA_WIDTH=8, ADDR_BITS=4, BURST_MAX=4)
REQ-032 The bench SHALL check: reset=0 for 2 cycles with req_a=req_b=1 -> all outputs 0 and no grant until 1 cycle after reset=1, then gnt_a=1.
REQ-033 The bench SHALL check: A alone sends 0x11, 0x22, 0x33 -> en_w with (addr 0, 0x11), (1, 0x22), (2, 0x33) each one cycle after its transfer; gnt_b stays 0.
REQ-034 The bench SHALL check: req_a=req_b=1 continuously -> A writes addresses 0-3, B writes 8-11, A writes 4-7 with wrap_a=1 at address 7, B writes 12-15 with wrap_b=1 at address 15.
REQ-035 The bench SHALL check: A alone for 10 transfers -> addresses 0..7,0,1; wrap_a=1 only at address 7; gnt_a stays high throughout.
REQ-036 The bench SHALL check: clear=1 during A's 3rd transfer -> no en_w for that word, FSM IDLE, next A write at address 0.
REQ-037 The bench SHALL check: reset=0 mid-burst of B at address 10 -> en_w=0 next cycle; after release, B's next write goes to address 8.

Source files
------------

// File: rtl/ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_write_arbiter
// Purpose  : Two-requester burst-limited write arbiter feeding a split-region RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk_w,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  en_w,
    output logic [ADDR_BITS-1:0]  write_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  wrap_a,
    output logic                  wrap_b
);

    localparam int PTR_BITS = ADDR_BITS - 1;
    localparam int CNT_BITS = $clog2(BURST_MAX + 1);
    localparam logic [CNT_BITS-1:0] BURST_LAST = CNT_BITS'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_BITS-1:0] burst_cnt, burst_cnt_next;
    logic                last_b, last_b_next;   // 1: B was granted most recently
    logic [PTR_BITS-1:0] ptr_a, ptr_b;          // region offsets; B's MSB is implied
    logic                xfer_a, xfer_b;

    assign xfer_a = req_a & gnt_a;
    assign xfer_b = req_b & gnt_b;

    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        last_b_next    = last_b;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || last_b))
                    state_next = GRANT_A;
                else if (req_b)
                    state_next = GRANT_B;
            end
            GRANT_A: begin
                if (!req_a)
                    state_next = req_b ? GRANT_B : IDLE;
                else if (burst_cnt == BURST_LAST) begin
                    if (req_b)
                        state_next = GRANT_B;
                    else
                        burst_cnt_next = '0;
                end else
                    burst_cnt_next = burst_cnt + 1'b1;
            end
            GRANT_B: begin
                if (!req_b)
                    state_next = req_a ? GRANT_A : IDLE;
                else if (burst_cnt == BURST_LAST) begin
                    if (req_a)
                        state_next = GRANT_A;
                    else
                        burst_cnt_next = '0;
                end else
                    burst_cnt_next = burst_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) begin
            burst_cnt_next = '0;
            if (state_next == GRANT_A)
                last_b_next = 1'b0;
            else if (state_next == GRANT_B)
                last_b_next = 1'b1;
        end
    end

    always_ff @(posedge clk_w) begin
        if (!reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_b     <= 1'b1;
            ptr_a      <= '0;
            ptr_b      <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            en_w       <= 1'b0;
            wrap_a     <= 1'b0;
            wrap_b     <= 1'b0;
            write_addr <= '0;
            data       <= '0;
        end else if (clear) begin
            // Same-cycle transfer is dropped; address/data keep their last values.
            state     <= IDLE;
            burst_cnt <= '0;
            last_b    <= 1'b1;
            ptr_a     <= '0;
            ptr_b     <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            en_w      <= 1'b0;
            wrap_a    <= 1'b0;
            wrap_b    <= 1'b0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
            last_b    <= last_b_next;
            gnt_a     <= (state_next == GRANT_A);
            gnt_b     <= (state_next == GRANT_B);
            en_w      <= xfer_a | xfer_b;
            wrap_a    <= xfer_a & (&ptr_a);
            wrap_b    <= xfer_b & (&ptr_b);
            if (xfer_a) begin
                write_addr <= {1'b0, ptr_a};
                data       <= data_a;
                ptr_a      <= ptr_a + 1'b1;
            end else if (xfer_b) begin
                write_addr <= {1'b1, ptr_b};
                data       <= data_b;
                ptr_b      <= ptr_b + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
